// File: rtl/memory_controller_pkg.sv
// Shared definitions for the memory controller: state encoding and default sizes.
// The WRITE_THROUGH_EN build option is handled in memory_controller.sv.
package memory_controller_pkg;

    localparam int DEFAULT_ADDR_W  = 32;
    localparam int DEFAULT_DATA_W  = 8;
    localparam int DEFAULT_INDEX_W = 8;
    localparam int DEFAULT_MEM_AW  = 16;

    // Tag bits stored per L1 line: the memory address bits above the index
    localparam int TAG_W = DEFAULT_MEM_AW - DEFAULT_INDEX_W;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        WRITEBACK,
        FILL
    } state_t;

endpackage

// File: rtl/mc_main_memory.sv
// Single-port main-memory array behind the L1: synchronous write, combinational read.
// Powers up with every word holding the low bits of its own address; reset never touches it.
module mc_main_memory
    import memory_controller_pkg::*;
#(
    parameter int AW = DEFAULT_MEM_AW,
    parameter int DW = DEFAULT_DATA_W
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    localparam int DEPTH = 1 << AW;

    typedef logic [DW-1:0] memArray_t [DEPTH];

    function automatic memArray_t powerUpImage();
        memArray_t img;
        for (int i = 0; i < DEPTH; i++) begin
            img[i] = DW'(i);
        end
        return img;
    endfunction

    memArray_t mem_q = powerUpImage();

    // Commit one word per cycle when the controller asks for a write
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/memory_controller.sv
// Byte-wide controller with a direct-mapped write-allocate L1 in front of main memory.
// Default build is write-back; defining WRITE_THROUGH_EN makes every write also update memory,
// so lines never go dirty and the WRITEBACK state is never entered.
module memory_controller
    import memory_controller_pkg::*;
#(
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int INDEX_W = DEFAULT_INDEX_W,
    parameter int MEM_AW  = DEFAULT_MEM_AW
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              rw,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out
);

    localparam int LINES    = 1 << INDEX_W;
    localparam int TAG_BITS = MEM_AW - INDEX_W;

`ifdef WRITE_THROUGH_EN
    localparam logic DIRTY_ON_WRITE = 1'b0;
`else
    localparam logic DIRTY_ON_WRITE = 1'b1;
`endif

    state_t              state_q;
    logic                reqRw_q;
    logic [MEM_AW-1:0]   reqAddr_q;
    logic [DATA_W-1:0]   reqData_q;
    logic [DATA_W-1:0]   dataOut_q;

    logic [LINES-1:0]    valid_q;
    logic [LINES-1:0]    dirty_q;
    logic [TAG_BITS-1:0] tagArr_q  [LINES];
    logic [DATA_W-1:0]   dataArr_q [LINES];

    logic [INDEX_W-1:0]  reqIndex;
    logic [TAG_BITS-1:0] reqTag;
    logic                lineHit;
    logic                memWe;
    logic [MEM_AW-1:0]   memAddr;
    logic [DATA_W-1:0]   memWdata;
    logic [DATA_W-1:0]   memRdata;

    // Address bits above main-memory range alias and are deliberately dropped
    logic unusedUpperAddr;
    assign unusedUpperAddr = ^address[ADDR_W-1:MEM_AW];

    assign reqIndex = reqAddr_q[INDEX_W-1:0];
    assign reqTag   = reqAddr_q[MEM_AW-1:INDEX_W];
    assign lineHit  = valid_q[reqIndex] && (tagArr_q[reqIndex] == reqTag);
    assign data_out = dataOut_q;

    // Memory port steering; reset suppresses any write so an in-flight write-back is dropped
    always_comb begin
        memWe    = 1'b0;
        memAddr  = {reqTag, reqIndex};
        memWdata = reqData_q;
        if (!reset_n) begin
`ifdef WRITE_THROUGH_EN
            if (reqRw_q && ((state_q == COMPARE && lineHit) || state_q == FILL)) begin
                memWe = 1'b1;
            end
`else
            if (state_q == WRITEBACK) begin
                memWe    = 1'b1;
                memAddr  = {tagArr_q[reqIndex], reqIndex};
                memWdata = dataArr_q[reqIndex];
            end
`endif
        end
    end

    mc_main_memory #(
        .AW (MEM_AW),
        .DW (DATA_W)
    ) u_mainMemory (
        .clk     (clk),
        .we_i    (memWe),
        .addr_i  (memAddr),
        .wdata_i (memWdata),
        .rdata_o (memRdata)
    );

    // Request FSM together with the L1 line arrays and the registered read result
    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_q   <= IDLE;
            valid_q   <= '0;
            dirty_q   <= '0;
            dataOut_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        reqRw_q   <= rw;
                        reqAddr_q <= address[MEM_AW-1:0];
                        reqData_q <= data_in;
                        state_q   <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (lineHit) begin
                        if (reqRw_q) begin
                            dataArr_q[reqIndex] <= reqData_q;
                            dirty_q[reqIndex]   <= DIRTY_ON_WRITE;
                        end else begin
                            dataOut_q <= dataArr_q[reqIndex];
                        end
                        state_q <= IDLE;
                    end else if (valid_q[reqIndex] && dirty_q[reqIndex]) begin
                        state_q <= WRITEBACK;
                    end else begin
                        state_q <= FILL;
                    end
                end
                WRITEBACK: begin
                    state_q <= FILL;
                end
                FILL: begin
                    valid_q[reqIndex]  <= 1'b1;
                    tagArr_q[reqIndex] <= reqTag;
                    if (reqRw_q) begin
                        dataArr_q[reqIndex] <= reqData_q;
                        dirty_q[reqIndex]   <= DIRTY_ON_WRITE;
                    end else begin
                        dataArr_q[reqIndex] <= memRdata;
                        dirty_q[reqIndex]   <= 1'b0;
                        dataOut_q           <= memRdata;
                    end
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_controller.sv
// Self-checking bench for memory_controller (default write-back build).
// A behavioural cache/memory model predicts read data and per-request latency.
module tb_memory_controller;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        rw;
    logic [31:0] address;
    logic [7:0]  data_in;
    logic [7:0]  data_out;

    int totalCount = 0;
    int badCount   = 0;

    logic [7:0] memModel  [65536];
    bit         validModel[256];
    bit         dirtyModel[256];
    logic [7:0] tagModel  [256];
    logic [7:0] lineModel [256];
    logic [7:0] outModel;

    always #5 clk = ~clk;

    memory_controller dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .rw       (rw),
        .address  (address),
        .data_in  (data_in),
        .data_out (data_out)
    );

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        totalCount++;
        if (observed !== expected) begin
            badCount++;
            $display("[TB] FAIL %s: observed=%02h expected=%02h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 256; i++) begin
            validModel[i] = 1'b0;
            dirtyModel[i] = 1'b0;
        end
        outModel = 8'h00;
    endtask

    // Hold reset for a few cycles, then confirm the read result register is cleared
    task automatic applyReset(input string tag);
        @(negedge clk);
        reset_n = 1'b1;
        enable  = 1'b0;
        repeat (3) @(negedge clk);
        modelReset();
        checkOutput(tag, data_out, 8'h00);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Update the model for one request and return its latency and resulting data_out
    task automatic modelRequest(input logic isWrite, input logic [31:0] addr, input logic [7:0] wdata,
                                output int lat);
        int idx;
        logic [7:0] tg;
        idx = int'(addr[7:0]);
        tg  = addr[15:8];
        if (validModel[idx] && tagModel[idx] == tg) begin
            lat = 1;
            if (isWrite) begin
                lineModel[idx]  = wdata;
                dirtyModel[idx] = 1'b1;
            end
        end else begin
            if (validModel[idx] && dirtyModel[idx]) begin
                lat = 3;
                memModel[{tagModel[idx], addr[7:0]}] = lineModel[idx];
            end else begin
                lat = 2;
            end
            validModel[idx] = 1'b1;
            tagModel[idx]   = tg;
            if (isWrite) begin
                lineModel[idx]  = wdata;
                dirtyModel[idx] = 1'b1;
            end else begin
                lineModel[idx]  = memModel[addr[15:0]];
                dirtyModel[idx] = 1'b0;
            end
        end
        if (!isWrite) outModel = lineModel[idx];
    endtask

    // Issue one request and check data_out after every edge up to one past the expected latency
    task automatic applyStimulus(input logic isWrite, input logic [31:0] addr, input logic [7:0] wdata,
                                 input string tag);
        int lat;
        logic [7:0] oldOut;
        oldOut = outModel;
        modelRequest(isWrite, addr, wdata, lat);
        @(negedge clk);
        enable  = 1'b1;
        rw      = isWrite;
        address = addr;
        data_in = wdata;
        @(negedge clk);
        enable  = 1'b0;
        rw      = 1'($urandom_range(0, 1));
        address = $urandom;
        data_in = 8'($urandom);
        @(posedge clk);
        for (int k = 1; k <= lat + 1; k++) begin
            if (k > 1) @(posedge clk);
            #1;
            checkOutput($sformatf("%s edge%0d", tag, k), data_out, (k < lat) ? oldOut : outModel);
        end
        repeat (4) @(negedge clk);
    endtask

    // Assert reset while a dirty victim is being written back; the write-back must be lost
    task automatic resetDuringWriteback(input logic [31:0] addr);
        int lat;
        logic [7:0] oldOut;
        logic [7:0] savedMem [65536];
        oldOut   = outModel;
        savedMem = memModel;
        modelRequest(1'b0, addr, 8'h00, lat);
        checkOutput("midwb expects dirty miss", 8'(lat), 8'd3);
        @(negedge clk);
        enable  = 1'b1;
        rw      = 1'b0;
        address = addr;
        @(negedge clk);
        enable  = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midwb edge1", data_out, oldOut);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        memModel = savedMem;
        modelReset();
        checkOutput("midwb reset clears", data_out, 8'h00);
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int lat;
        logic        isWrite;
        logic [31:0] addr;
        logic [7:0]  idxPick;
        logic [7:0]  tagPick;

        for (int i = 0; i < 65536; i++) memModel[i] = 8'(i);
        modelReset();
        reset_n = 1'b0;
        enable  = 1'b0;
        rw      = 1'b0;
        address = '0;
        data_in = '0;

        applyReset("reset data_out");

        applyStimulus(1'b1, 32'h0000_4010, 8'hAA, "write 4010 miss");
        applyStimulus(1'b0, 32'h0000_4010, 8'h00, "read 4010 hit");
        checkOutput("plan read 4010 value", data_out, 8'hAA);
        applyStimulus(1'b0, 32'h0000_1000, 8'h00, "read 1000 clean miss");
        applyStimulus(1'b0, 32'h0000_1000, 8'h00, "read 1000 hit");
        applyStimulus(1'b0, 32'h0000_8010, 8'h00, "read 8010 dirty miss");
        checkOutput("plan read 8010 value", data_out, 8'h10);
        applyStimulus(1'b0, 32'h0000_4010, 8'h00, "read 4010 after writeback");
        checkOutput("plan writeback value", data_out, 8'hAA);
        applyStimulus(1'b0, 32'h0000_8010, 8'h00, "read 8010 clean victim");
        applyStimulus(1'b0, 32'hFFFF_8010, 8'h00, "read 8010 aliased hit");

        applyStimulus(1'b1, 32'h0000_4010, 8'h55, "write 4010 make dirty");
        resetDuringWriteback(32'h0000_8010);
        applyStimulus(1'b0, 32'h0000_8010, 8'h00, "read 8010 after abort");
        applyStimulus(1'b0, 32'h0000_4010, 8'h00, "read 4010 after abort");
        checkOutput("lost writeback value", data_out, 8'hAA);

        for (int n = 0; n < 240; n++) begin
            if (n % 60 == 59) applyReset("random reset");
            isWrite = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       idxPick = 8'h10;
                1:       idxPick = 8'h11;
                2:       idxPick = 8'hFF;
                default: idxPick = 8'($urandom);
            endcase
            tagPick = 8'($urandom_range(0, 3) * 8'h41);
            addr = {16'($urandom), tagPick, idxPick};
            applyStimulus(isWrite, addr, 8'($urandom), $sformatf("rand%0d %s %08h", n, isWrite ? "wr" : "rd", addr));
        end

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule

// File: doc/memory_controller.md
# memory_controller

Byte-wide memory controller with a direct-mapped, write-back, write-allocate L1 cache in front of an internal main-memory array. It accepts single-cycle read/write requests from a processor-side requester and services them from L1 on a hit. On a miss it fills from main memory, first writing back a dirty victim. It is the sole path between the requester and main memory.

## Interface
- ADDR_W, 32: request address width.
- DATA_W, 8: data width; one cache line holds one DATA_W word.
- INDEX_W, 8: L1 index bits, 2^INDEX_W lines.
- MEM_AW, 16: main-memory address bits, 2^MEM_AW words.
- clk  in  1  the only clock; all logic on the rising edge.
- reset_n  in  1  synchronous, active-high reset (asserted = 1, despite the name).
- enable  in  1  request strobe, sampled only in IDLE.
- rw  in  1  1 = write, 0 = read.
- address  in  ADDR_W  byte address.
- data_in  in  DATA_W  write data.
- data_out  out  DATA_W  read result, registered, held until the next read completes.

## Operation
- Address split: index = address[INDEX_W-1:0]; tag = address[MEM_AW-1:INDEX_W]; address[ADDR_W-1:MEM_AW] is ignored and aliases.
- Each L1 line holds valid, dirty, tag and data.
- Main memory power-up content is mem[i] = i[7:0]. Reset does not clear it.
- FSM states are IDLE, COMPARE, WRITEBACK and FILL.
- IDLE:
  - enable = 1 latches rw, address and data_in, then goes to COMPARE.
  - enable in any other state is ignored.
- COMPARE:
  - Hit means valid and tag match.
  - Read hit: data_out <= line data, go to IDLE.
  - Write hit: line data <= data_in, dirty <= 1, go to IDLE.
  - Miss with valid and dirty victim: go to WRITEBACK.
  - Any other miss: go to FILL.
- WRITEBACK: mem[{victim tag, index}] <= victim data, go to FILL.
- FILL, read:
  - line <= {valid = 1, dirty = 0, new tag, mem[{tag, index}]}.
  - data_out <= the same memory word.
  - Go to IDLE.
- FILL, write (write-allocate, no memory read):
  - line <= {valid = 1, dirty = 1, new tag, data_in}.
  - Go to IDLE.
- Writes never change data_out.
- A read of a line in the same cycle it is written is impossible, because requests are serialized.

## Timing
- Reset values: state = IDLE, all valid = 0, all dirty = 0, data_out = 0. Tag and data arrays are not reset.
- Reset asserted in any state aborts the operation; a pending write-back is lost.
- Latency is counted in edges after the edge that samples enable:
  - hit: 1;
  - clean miss: 2;
  - dirty miss: 3.
- data_out is valid after the final edge of a read.
- The requester spaces requests by at least 4 idle cycles. There is no busy output; a request arriving outside IDLE is dropped.

## Configuration
- WRITE_THROUGH_EN defined:
  - Every write also writes mem[{tag, index}] in the same cycle it updates L1.
  - dirty is never set and WRITEBACK is unreachable.
- WRITE_THROUGH_EN undefined: write-back behaviour as specified above (default).

## Structure
- Package memory_controller_pkg holds:
  - the state enumeration (IDLE, COMPARE, WRITEBACK, FILL);
  - the default width constants;
  - the derived TAG_W = MEM_AW - INDEX_W.
- Sub-module mc_main_memory is the single-port synchronous array (one read or write per cycle, combinational read). It is instantiated once.
- The L1 arrays and the FSM stay in memory_controller.

## Test plan
- Reset, then write 0xAA to 0x00004010 -> no change to data_out (stays 0x00); line 0x10 valid and dirty.
- Read 0x00004010 -> hit; data_out = 0xAA one edge after the sampling edge.
- Read 0x00001000 -> clean miss; data_out = 0x00 after 2 edges. A repeat read hits, still 0x00.
- Read 0x00008010 -> dirty miss:
  - data_out = 0x10 after 3 edges;
  - mem[0x4010] = 0xAA.
- Read 0x00004010 -> miss; data_out = 0xAA, which proves the write-back. A following read of 0x00008010 misses with a clean victim, 2 edges, returns 0x10.
- Assert reset_n mid-WRITEBACK -> state IDLE, data_out = 0; the next read of the same address misses.
